// File: rtl/mem_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the data-memory access controller: the controller
// FSM state type, the ResultSrcM encoding that marks a load, and the default
// timeout length used when the parent does not override TIMEOUT.
// ----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    // IDLE issues, ACCESS waits for the memory, DONE releases the pipeline
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    // ResultSrcM value selecting memory read data for writeback
    localparam logic [1:0] RESULT_MEM = 2'b01;

    // Cycles ACCESS may wait for mem_ready before the access is aborted
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the stall-cycle statistic. It counts one per
// cycle while inc is high, sticks at all-ones instead of wrapping, and is
// zeroed synchronously by clear.
//
// Ports:
//   clk    in   clock
//   clear  in   synchronous clear, takes priority over inc
//   inc    in   count enable for this cycle
//   count  out  current count value (W bits)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Hold at all-ones once reached so the statistic never wraps to zero
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
// Serialises memory-stage loads and stores onto a simple request/ready data
// memory port. While an access is outstanding the whole pipeline is frozen;
// once it completes (or times out) the pipeline gets a single release cycle
// before the next access can be issued.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   MemWriteM      memory-stage instruction is a store
//   ResultSrcM     memory-stage result select (RESULT_MEM marks a load)
//   AluResultM     effective byte address
//   WriteDataM     store data
//   mem_req        registered memory request
//   mem_we         registered write flag for the request
//   mem_addr       latched request address
//   mem_wdata      latched store data
//   mem_ready      completion strobe, only looked at in ACCESS
//   mem_rdata      load data, valid together with mem_ready
//   ReadDataM      captured load data for writeback
//   StallPipe      freeze enable for the F..M pipeline registers
//   BusErr         one-cycle pulse when an access times out
//   MisalignErr    one-cycle pulse when a misaligned access is rejected
//   StallCycles    saturating count of cycles with StallPipe high
// ----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [31:0]      AluResultM,
    input  logic [31:0]      WriteDataM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      ReadDataM,
    output logic             StallPipe,
    output logic             BusErr,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] StallCycles
);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] read_data_q, read_data_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_err_q, misalign_err_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        stall_raw;
    logic        pending;
    logic        aligned;

    assign pending = MemWriteM | (ResultSrcM == RESULT_MEM);
    assign aligned = (AluResultM[1:0] == 2'b00);

    // Next-state and registered-output computation. Request fields are only
    // loaded on issue from IDLE, so they stay frozen for the whole ACCESS
    // stay. A ready seen on the last permitted cycle is taken as a normal
    // completion because that branch is checked before the timeout branch.
    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        read_data_d    = read_data_q;
        bus_err_d      = 1'b0;
        misalign_err_d = 1'b0;
        tcnt_d         = tcnt_q;
        stall_raw      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending) begin
                    if (aligned) begin
                        stall_raw   = 1'b1;
                        mem_addr_d  = AluResultM;
                        mem_wdata_d = WriteDataM;
                        mem_we_d    = MemWriteM;
                        mem_req_d   = 1'b1;
                        tcnt_d      = 8'd0;
                        state_d     = ACCESS;
                    end else begin
                        misalign_err_d = 1'b1;
                        read_data_d    = 32'd0;
                    end
                end
            end

            ACCESS: begin
                stall_raw = 1'b1;
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        read_data_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                    mem_req_d   = 1'b0;
                    read_data_d = 32'd0;
                    bus_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            read_data_q    <= 32'd0;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
            tcnt_q         <= 8'd0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            read_data_q    <= read_data_d;
            bus_err_q      <= bus_err_d;
            misalign_err_q <= misalign_err_d;
            tcnt_q         <= tcnt_d;
        end
    end

    // The IDLE issue decision is combinational on the M-stage inputs, so the
    // freeze must be masked during reset to keep the pipeline moving
    assign StallPipe = stall_raw & ~rst;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (StallPipe),
        .count (StallCycles)
    );

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign ReadDataM   = read_data_q;
    assign BusErr      = bus_err_q;
    assign MisalignErr = misalign_err_q;

endmodule
